// File: rtl/softmax_ctrl.sv
// Softmax initiator: collects serial logits, runs the softmax engine under a watchdog,
// then scans the returned probabilities for the argmax and offers it on a valid/ready port.
module softmax_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned INPUT_NUM  = 7,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [DATA_WIDTH*INPUT_NUM-1:0]  sm_inputs,
   output logic                             sm_enable,
   input  logic [DATA_WIDTH*INPUT_NUM-1:0]  sm_outputs,
   input  logic                             sm_valid,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [2:0]                       res_class,
   output logic [DATA_WIDTH-1:0]            res_prob,
   output logic [DATA_WIDTH*INPUT_NUM-1:0]  res_probs,
   output logic                             res_timeout
);

   localparam int unsigned VecW = DATA_WIDTH * INPUT_NUM;

   typedef enum logic [1:0] {StIdle, StRun, StScan, StDone} state_e;

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;
   logic [7:0]            wd_q, wd_d;
   logic [VecW-1:0]       sm_inputs_q, sm_inputs_d;
   logic                  sm_enable_q, sm_enable_d;
   logic [VecW-1:0]       res_probs_q, res_probs_d;
   logic [2:0]            res_class_q, res_class_d;
   logic [DATA_WIDTH-1:0] res_prob_q, res_prob_d;
   logic                  res_timeout_q, res_timeout_d;
   logic [DATA_WIDTH-1:0] elem;

   // Map sign-magnitude to an unsigned key that orders like the float; -0 folds onto +0.
   function automatic logic [DATA_WIDTH-1:0] ord_key(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-2:0] mag;
      mag = v[DATA_WIDTH-2:0];
      if (v[DATA_WIDTH-1] && (mag != '0)) begin
         return {1'b0, ~mag};
      end
      return {1'b1, mag};
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      wd_d          = wd_q;
      sm_inputs_d   = sm_inputs_q;
      sm_enable_d   = sm_enable_q;
      res_probs_d   = res_probs_q;
      res_class_d   = res_class_q;
      res_prob_d    = res_prob_q;
      res_timeout_d = res_timeout_q;
      elem          = res_probs_q[DATA_WIDTH*int'(idx_q) +: DATA_WIDTH];

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sm_inputs_d[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] = in_data;
               if (cnt_q == 3'(INPUT_NUM - 1)) begin
                  cnt_d       = '0;
                  wd_d        = '0;
                  sm_enable_d = 1'b1;
                  state_d     = StRun;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         StRun: begin
            // A completing softmax takes priority over the watchdog on the same edge.
            if (sm_valid) begin
               res_probs_d = sm_outputs;
               sm_enable_d = 1'b0;
               idx_d       = '0;
               state_d     = StScan;
            end else if (wd_q == 8'(TIMEOUT - 1)) begin
               sm_enable_d   = 1'b0;
               res_timeout_d = 1'b1;
               res_class_d   = 3'd7;
               res_prob_d    = '0;
               res_probs_d   = '0;
               state_d       = StDone;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         StScan: begin
            if ((idx_q == '0) || (ord_key(elem) > ord_key(res_prob_q))) begin
               res_class_d = idx_q;
               res_prob_d  = elem;
            end
            if (idx_q == 3'(INPUT_NUM - 1)) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         StDone: begin
            if (res_ready) begin
               res_timeout_d = 1'b0;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         idx_q         <= '0;
         wd_q          <= '0;
         sm_inputs_q   <= '0;
         sm_enable_q   <= 1'b0;
         res_probs_q   <= '0;
         res_class_q   <= '0;
         res_prob_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         wd_q          <= wd_d;
         sm_inputs_q   <= sm_inputs_d;
         sm_enable_q   <= sm_enable_d;
         res_probs_q   <= res_probs_d;
         res_class_q   <= res_class_d;
         res_prob_q    <= res_prob_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign res_valid   = (state_q == StDone);
   assign sm_inputs   = sm_inputs_q;
   assign sm_enable   = sm_enable_q;
   assign res_probs   = res_probs_q;
   assign res_class   = res_class_q;
   assign res_prob    = res_prob_q;
   assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_softmax_ctrl.sv
// Directed bench for softmax_ctrl with a behavioural softmax responder on the falling edge.
module tb_softmax_ctrl;

   localparam int DW = 8;
   localparam int N  = 7;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [55:0]   sm_inputs;
   logic          sm_enable;
   logic [55:0]   sm_outputs;
   logic          sm_valid;
   logic          res_valid;
   logic          res_ready;
   logic [2:0]    res_class;
   logic [DW-1:0] res_prob;
   logic [55:0]   res_probs;
   logic          res_timeout;

   int          checks = 0;
   int          errors = 0;
   logic        model_respond;
   logic [55:0] model_probs;
   int          mcnt;

   softmax_ctrl #(.DATA_WIDTH(DW), .INPUT_NUM(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sm_inputs(sm_inputs), .sm_enable(sm_enable), .sm_outputs(sm_outputs),
      .sm_valid(sm_valid), .res_valid(res_valid), .res_ready(res_ready),
      .res_class(res_class), .res_prob(res_prob), .res_probs(res_probs),
      .res_timeout(res_timeout)
   );

   always #5 clk = ~clk;

   // Softmax stand-in: raises valid a few falling edges after enable, clears when enable drops.
   always @(negedge clk) begin
      if (!sm_enable) begin
         mcnt     <= 0;
         sm_valid <= 1'b0;
      end else if (model_respond) begin
         mcnt <= mcnt + 1;
         if (mcnt >= 3) sm_valid <= 1'b1;
      end
   end
   assign sm_outputs = model_probs;

   task automatic send_beats(input logic [55:0] v, input int count);
      for (int k = 0; k < count; k++) begin
         in_valid = 1'b1;
         in_data  = v[8*k +: 8];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int n);
      int guard;
      guard = 0;
      n     = 0;
      while (sm_enable && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      while (!res_valid && guard < 200) begin
         @(posedge clk); #1;
         n++;
         guard++;
      end
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
      model_respond = 1'b1; model_probs = '0;
      #12;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
      checks++; if (sm_enable !== 1'b0) begin errors++; $display("FAIL reset_sm_enable got %0b exp 0", sm_enable); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b exp 0", res_valid); end
      checks++;
      if ({res_class, res_prob, res_timeout} !== '0 || res_probs !== '0 || sm_inputs !== '0) begin
         errors++;
         $display("FAIL reset_outputs got class %0d prob %h to %0b probs %h inputs %h exp all 0",
                  res_class, res_prob, res_timeout, res_probs, sm_inputs);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_argmax();
      int n;
      model_probs = 56'h02_04_20_3A_08_18_10;
      send_beats(56'h10_20_3C_44_30_40_38, 7);
      checks++; if (sm_enable !== 1'b1) begin errors++; $display("FAIL argmax_enable_latency got %0b exp 1", sm_enable); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL argmax_in_ready_run got %0b exp 0", in_ready); end
      checks++;
      if (sm_inputs !== 56'h10_20_3C_44_30_40_38) begin
         errors++; $display("FAIL argmax_packing got %h exp 10203c44304038", sm_inputs);
      end
      wait_result(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL argmax_scan_latency got %0d exp 7", n); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL argmax_res_valid got %0b exp 1", res_valid); end
      checks++; if (res_class !== 3'd3) begin errors++; $display("FAIL argmax_class got %0d exp 3", res_class); end
      checks++; if (res_prob !== 8'h3A) begin errors++; $display("FAIL argmax_prob got %h exp 3a", res_prob); end
      checks++;
      if (res_probs !== 56'h02_04_20_3A_08_18_10) begin
         errors++; $display("FAIL argmax_probs got %h exp 0204203a081810", res_probs);
      end
      checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL argmax_timeout got %0b exp 0", res_timeout); end
      ack();
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_class !== 3'd3) begin
         errors++;
         $display("FAIL argmax_after_ack got valid %0b ready %0b class %0d exp 0 1 3",
                  res_valid, in_ready, res_class);
      end
   endtask

   task automatic test_ties();
      logic [55:0] tab [5];
      logic [2:0]  ecls [5];
      logic [7:0]  eprb [5];
      int n;
      tab[0] = 56'h20_20_20_20_20_20_20; ecls[0] = 3'd0; eprb[0] = 8'h20;
      tab[1] = 56'h00_00_00_00_00_00_80; ecls[1] = 3'd0; eprb[1] = 8'h80;
      tab[2] = 56'h84_FF_82_90_81_83_85; ecls[2] = 3'd2; eprb[2] = 8'h81;
      tab[3] = 56'h00_00_01_00_00_00_80; ecls[3] = 3'd4; eprb[3] = 8'h01;
      tab[4] = 56'h10_30_10_10_30_10_10; ecls[4] = 3'd2; eprb[4] = 8'h30;
      for (int t = 0; t < 5; t++) begin
         model_probs = tab[t];
         send_beats(56'h01_02_03_04_05_06_07, 7);
         wait_result(n);
         checks++;
         if (res_valid !== 1'b1 || res_class !== ecls[t] || res_prob !== eprb[t]) begin
            errors++;
            $display("FAIL ties_%0d got valid %0b class %0d prob %h exp 1 %0d %h",
                     t, res_valid, res_class, res_prob, ecls[t], eprb[t]);
         end
         ack();
      end
   endtask

   task automatic test_timeout();
      int n;
      model_respond = 1'b0;
      send_beats(56'h11_22_33_44_55_66_77, 7);
      n = 0;
      while (sm_enable && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n !== 16) begin errors++; $display("FAIL timeout_enable_cycles got %0d exp 16", n); end
      checks++;
      if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_class !== 3'd7 || res_prob !== 8'h00) begin
         errors++;
         $display("FAIL timeout_result got valid %0b to %0b class %0d prob %h exp 1 1 7 00",
                  res_valid, res_timeout, res_class, res_prob);
      end
      checks++; if (res_probs !== '0) begin errors++; $display("FAIL timeout_probs got %h exp 0", res_probs); end
      ack();
      checks++;
      if (res_timeout !== 1'b0 || in_ready !== 1'b1 || res_class !== 3'd7) begin
         errors++;
         $display("FAIL timeout_after_ack got to %0b ready %0b class %0d exp 0 1 7",
                  res_timeout, in_ready, res_class);
      end
      model_respond = 1'b1;
   endtask

   task automatic test_back_to_back();
      int n;
      model_probs = 56'h10_50_20_30_01_02_03;
      send_beats(56'h0A_0B_0C_0D_0E_0F_09, 7);
      wait_result(n);
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
         checks++;
         if (res_valid !== 1'b1 || res_class !== 3'd5 || res_prob !== 8'h50 || in_ready !== 1'b0 ||
             res_probs !== 56'h10_50_20_30_01_02_03) begin
            errors++;
            $display("FAIL hold_cycle_%0d got valid %0b class %0d prob %h ready %0b exp 1 5 50 0",
                     c, res_valid, res_class, res_prob, in_ready);
         end
      end
      in_valid = 1'b0;
      ack();
      checks++;
      if (in_ready !== 1'b1 || sm_enable !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle got ready %0b enable %0b exp 1 0", in_ready, sm_enable);
      end
      model_probs = 56'h01_01_01_01_01_01_7F;
      send_beats(56'h71_72_73_74_75_76_77, 7);
      checks++;
      if (sm_inputs !== 56'h71_72_73_74_75_76_77 || sm_enable !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_run got inputs %h enable %0b exp 71727374757677 1",
                  sm_inputs, sm_enable);
      end
      wait_result(n);
      checks++; if (res_class !== 3'd0) begin errors++; $display("FAIL b2b_class got %0d exp 0", res_class); end
      ack();
   endtask

   task automatic test_reset_mid();
      int n;
      model_respond = 1'b0;
      send_beats(56'h21_22_23_24_25_26_27, 7);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++;
      if (sm_enable !== 1'b0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run got enable %0b ready %0b valid %0b exp 0 1 0",
                  sm_enable, in_ready, res_valid);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      model_respond = 1'b1;
      send_beats(56'h31_32_33_34_35_36_37, 4);
      rst_n = 1'b0;
      #1;
      checks++;
      if (sm_inputs !== '0 || in_ready !== 1'b1 || sm_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_collect got inputs %h ready %0b enable %0b exp 0 1 0",
                  sm_inputs, in_ready, sm_enable);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      model_probs = 56'h01_02_03_04_05_60_07;
      send_beats(56'h41_42_43_44_45_46_47, 7);
      checks++;
      if (sm_inputs !== 56'h41_42_43_44_45_46_47 || sm_enable !== 1'b1) begin
         errors++;
         $display("FAIL reset_fresh_vector got inputs %h enable %0b exp 41424344454647 1",
                  sm_inputs, sm_enable);
      end
      wait_result(n);
      checks++; if (res_class !== 3'd1) begin errors++; $display("FAIL reset_fresh_class got %0d exp 1", res_class); end
      ack();
   endtask

   task automatic test_random_valid();
      logic [55:0] v;
      int accepted;
      int guard;
      logic iv;
      logic rdy;
      int n;
      v = 56'hA1_B2_C3_D4_E5_F6_17;
      accepted = 0;
      guard = 0;
      while (accepted < 7 && guard < 200) begin
         iv       = 1'($urandom_range(0, 1));
         in_valid = iv;
         in_data  = iv ? v[8*accepted +: 8] : 8'hEE;
         rdy      = in_ready;
         @(posedge clk); #1;
         if (iv && rdy) accepted++;
         guard++;
      end
      in_valid = 1'b0;
      checks++;
      if (accepted !== 7 || sm_enable !== 1'b1) begin
         errors++;
         $display("FAIL random_accept got beats %0d enable %0b exp 7 1", accepted, sm_enable);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = 8'h5A;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (sm_inputs !== 56'hA1_B2_C3_D4_E5_F6_17) begin
         errors++; $display("FAIL random_packing got %h exp a1b2c3d4e5f617", sm_inputs);
      end
      wait_result(n);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL random_result got %0b exp 1", res_valid); end
      ack();
   endtask

   initial begin
      test_reset();
      test_argmax();
      test_ties();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random_valid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got running exp finished");
      $fatal(1, "time limit");
   end

endmodule
